pwm_pulse_gen: RTL and testbench



---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_pulse_gen_slot_timer.sv | 29 ++
 rtl/pwm_pulse_gen.sv | 177 +++++++++++++++++
 tb/tb_pwm_pulse_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM pulse generator: FSM encoding, control bit
// positions and default field widths.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } pwm_state_t;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_STOP  = 1;

    localparam int unsigned DEF_DUTY_WIDTH = 8;
    localparam int unsigned DEF_DEAD_WIDTH = 17;
    localparam int unsigned DEF_PAT_WIDTH  = 32;

endpackage

// File: rtl/pwm_pulse_gen_slot_timer.sv
// Loadable down-counter shared by the HIGH and LOW phases; last flags the
// final clock of the current phase.
module pwm_slot_timer
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DEAD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/pwm_pulse_gen.sv
// Single-channel gated pulse-train generator with busy/valid/done status.
// Optional per-slot pattern masking is enabled by defining PWM_PAT_EN.
module pwm_pulse_gen
    import pwm_pkg::*;
#(
    parameter int unsigned _PAT_WIDTH  = DEF_PAT_WIDTH,
    parameter int unsigned _DUTY_WIDTH = DEF_DUTY_WIDTH,
    parameter int unsigned _DEAD_WIDTH = DEF_DEAD_WIDTH
) (
    input  logic                   clk_100M,
    input  logic                   rst_n,
    input  logic                   cfg_wr,
    input  logic [7:0]             ctrl_sta,
    input  logic [_DUTY_WIDTH-1:0] duty_num,
    input  logic [_DEAD_WIDTH-1:0] pulse_dessert,
    input  logic [7:0]             pulse_num,
    input  logic [_PAT_WIDTH-1:0]  pat,
    output logic                   pwm_out,
    output logic                   pwm_busy,
    output logic                   pwm_valid,
    output logic                   pwm_done
);

    pwm_state_t state, state_n;

    logic [_DUTY_WIDTH-1:0] duty_q, duty_n;
    logic [_DEAD_WIDTH-1:0] dessert_q, dessert_n;
    logic [7:0]             num_q, num_n;
    logic [7:0]             cnt_q, cnt_n;
    logic                   valid_n, out_n, busy_n, done_n;
    logic                   start, stop, slot_end;
    logic                   timer_load, timer_last;
    logic [_DEAD_WIDTH-1:0] timer_val;
    logic                   unused_inputs;

`ifdef PWM_PAT_EN
    localparam int unsigned IDX_W = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
    logic [_PAT_WIDTH-1:0] pat_q, pat_n;
    logic [IDX_W-1:0]      idx_q, idx_n;

    assign unused_inputs = ^ctrl_sta[7:2];
`else
    assign unused_inputs = ^{ctrl_sta[7:2], pat};
`endif

    assign stop  = cfg_wr & ctrl_sta[CTRL_STOP];
    assign start = cfg_wr & ctrl_sta[CTRL_START] & ~stop;

    pwm_slot_timer #(.WIDTH(_DEAD_WIDTH)) u_timer (
        .clk      (clk_100M),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    always_comb begin
        state_n    = state;
        duty_n     = duty_q;
        dessert_n  = dessert_q;
        num_n      = num_q;
        cnt_n      = cnt_q;
        valid_n    = pwm_valid;
        timer_load = 1'b0;
        timer_val  = '0;
        slot_end   = 1'b0;
`ifdef PWM_PAT_EN
        pat_n      = pat_q;
        idx_n      = idx_q;
`endif

        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state_n = IDLE;
                    if (start) begin
                        if (duty_num == '0) begin
                            valid_n = 1'b0;
                        end else begin
                            duty_n     = duty_num;
                            dessert_n  = pulse_dessert;
                            num_n      = pulse_num;
                            cnt_n      = '0;
                            valid_n    = 1'b1;
                            state_n    = HIGH;
                            timer_load = 1'b1;
                            timer_val  = _DEAD_WIDTH'(duty_num);
`ifdef PWM_PAT_EN
                            pat_n      = pat;
                            idx_n      = '0;
`endif
                        end
                    end
                end
                HIGH: begin
                    if (timer_last) begin
                        if (dessert_q == '0) begin
                            slot_end = 1'b1;
                        end else begin
                            state_n    = LOW;
                            timer_load = 1'b1;
                            timer_val  = dessert_q;
                        end
                    end
                end
                LOW: begin
                    if (timer_last) begin
                        slot_end = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Slot advance is shared by HIGH (zero dead time) and LOW exits.
        if (slot_end) begin
            cnt_n = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef PWM_PAT_EN
            idx_n = (idx_q == IDX_W'(_PAT_WIDTH - 1)) ? '0 : idx_q + 1'b1;
`endif
            if ((num_q != '0) && ({1'b0, cnt_q} + 9'd1 == {1'b0, num_q})) begin
                state_n = DONE;
            end else begin
                state_n    = HIGH;
                timer_load = 1'b1;
                timer_val  = _DEAD_WIDTH'(duty_q);
            end
        end

        // Outputs are precomputed from the next state so they can be registered.
        out_n  = 1'b0;
        if (state_n == HIGH) begin
`ifdef PWM_PAT_EN
            out_n = pat_n[idx_n];
`else
            out_n = 1'b1;
`endif
        end
        busy_n = (state_n == HIGH) || (state_n == LOW);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty_q    <= '0;
            dessert_q <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            pwm_valid <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_busy  <= 1'b0;
            pwm_done  <= 1'b0;
`ifdef PWM_PAT_EN
            pat_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            duty_q    <= duty_n;
            dessert_q <= dessert_n;
            num_q     <= num_n;
            cnt_q     <= cnt_n;
            pwm_valid <= valid_n;
            pwm_out   <= out_n;
            pwm_busy  <= busy_n;
            pwm_done  <= done_n;
`ifdef PWM_PAT_EN
            pat_q     <= pat_n;
            idx_q     <= idx_n;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// Scoreboard bench for pwm_pulse_gen: stimulus queues per-cycle expected
// {out,busy,done,valid}; a negedge monitor pops and compares.
module tb_pwm_pulse_gen;

`ifdef PWM_PAT_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [7:0]  ctrl_sta;
    logic [7:0]  duty_num;
    logic [16:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [31:0] pat;
    logic        pwm_out, pwm_busy, pwm_valid, pwm_done;

    typedef struct {
        logic [3:0] vec;
        string      name;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_100M = ~clk_100M;

    pwm_pulse_gen #(
        ._PAT_WIDTH (32),
        ._DUTY_WIDTH(8),
        ._DEAD_WIDTH(17)
    ) dut (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .cfg_wr       (cfg_wr),
        .ctrl_sta     (ctrl_sta),
        .duty_num     (duty_num),
        .pulse_dessert(pulse_dessert),
        .pulse_num    (pulse_num),
        .pat          (pat),
        .pwm_out      (pwm_out),
        .pwm_busy     (pwm_busy),
        .pwm_valid    (pwm_valid),
        .pwm_done     (pwm_done)
    );

    // Timing model: slot k starts at cycle 1 + k*(d+s); done at 1 + n*(d+s).
    function automatic logic [3:0] model(input int c, input int d, input int s,
                                         input int n, input logic [31:0] p, input logic v);
        int   l, slot, pos;
        logic o, b, dn;
        l = d + s;
        o = 1'b0; b = 1'b0; dn = 1'b0;
        if (n != 0 && c == 1 + n * l) begin
            dn = 1'b1;
        end else if (n == 0 || c < 1 + n * l) begin
            slot = (c - 1) / l;
            pos  = (c - 1) % l;
            b    = 1'b1;
            o    = (pos < d) && (PAT_EN ? p[slot % 32] : 1'b1);
        end
        return {o, b, dn, v};
    endfunction

    task automatic push_train(input string name, input int d, input int s, input int n,
                              input logic [31:0] p, input int first, input int last_c);
        for (int c = first; c <= last_c; c++) begin
            exp_q.push_back('{vec: model(c, d, s, n, p, 1'b1), name: name, cyc: c});
        end
    endtask

    task automatic push_const(input string name, input logic [3:0] v, input int first,
                              input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back('{vec: v, name: name, cyc: first + i});
        end
    endtask

    task automatic drive_cfg(input logic [7:0] c, input int d, input int s, input int n,
                             input logic [31:0] p);
        @(negedge clk_100M);
        #1;
        ctrl_sta      = c;
        duty_num      = d[7:0];
        pulse_dessert = s[16:0];
        pulse_num     = n[7:0];
        pat           = p;
        cfg_wr        = 1'b1;
    endtask

    task automatic end_cfg();
        @(posedge clk_100M);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 500) begin
            @(posedge clk_100M);
            k++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk_100M) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = exp_q.pop_front();
            act = {pwm_out, pwm_busy, pwm_done, pwm_valid};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s cycle %0d: out/busy/done/valid got %b required %b",
                         e.name, e.cyc, act, e.vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; ctrl_sta = '0; duty_num = '0;
        pulse_dessert = '0; pulse_num = '0; pat = '0;
        repeat (3) @(posedge clk_100M);
        @(negedge clk_100M);
        #1;
        push_const("reset", 4'b0000, 0, 3);
        @(posedge clk_100M);
        #1;
        rst_n = 1'b1;
        drain("reset");

        drive_cfg(8'h01, 3, 2, 2, 32'hFFFF_FFFF);
        push_train("basic", 3, 2, 2, 32'hFFFF_FFFF, 1, 12);
        end_cfg();
        drain("basic");

        drive_cfg(8'h01, 2, 1, 4, 32'h0000_0005);
        push_train("mask", 2, 1, 4, 32'h0000_0005, 1, 14);
        end_cfg();
        drain("mask");

        drive_cfg(8'h01, 4, 0, 3, 32'hFFFF_FFFF);
        push_train("zero_dead", 4, 0, 3, 32'hFFFF_FFFF, 1, 14);
        end_cfg();
        drain("zero_dead");

        drive_cfg(8'h01, 5, 5, 0, 32'hFFFF_FFFF);
        push_train("stop", 5, 5, 0, 32'hFFFF_FFFF, 1, 7);
        push_const("stop", 4'b0001, 8, 5);
        end_cfg();
        repeat (6) @(negedge clk_100M);
        drive_cfg(8'h02, 5, 5, 0, 32'hFFFF_FFFF);
        end_cfg();
        drain("stop");

        drive_cfg(8'h01, 0, 3, 1, 32'hFFFF_FFFF);
        push_const("duty0", 4'b0000, 1, 3);
        end_cfg();
        drain("duty0");

        drive_cfg(8'h01, 2, 2, 2, 32'hFFFF_FFFF);
        push_train("start_busy", 2, 2, 2, 32'hFFFF_FFFF, 1, 10);
        end_cfg();
        repeat (2) @(negedge clk_100M);
        drive_cfg(8'h01, 7, 0, 1, 32'h0000_0000);
        end_cfg();
        drain("start_busy");

        drive_cfg(8'h03, 4, 1, 1, 32'hFFFF_FFFF);
        push_const("start_stop", 4'b0001, 1, 3);
        end_cfg();
        drain("start_stop");

        // Reset lands mid-cycle 3, before any further clock edge.
        drive_cfg(8'h01, 6, 2, 0, 32'hFFFF_FFFF);
        push_train("rst_mid", 6, 2, 0, 32'hFFFF_FFFF, 1, 2);
        push_const("rst_mid", 4'b0000, 3, 3);
        end_cfg();
        @(posedge clk_100M);
        @(posedge clk_100M);
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_100M);
        #1;
        rst_n = 1'b1;
        drain("rst_mid");

        drive_cfg(8'h01, 1, 1, 0, 32'h0000_0001);
        push_train("wrap", 1, 1, 0, 32'h0000_0001, 1, 130);
        push_const("wrap", 4'b0001, 131, 3);
        end_cfg();
        repeat (129) @(negedge clk_100M);
        drive_cfg(8'h02, 1, 1, 0, 32'h0000_0001);
        end_cfg();
        drain("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
